// File: rtl/ds_operand_unit_pkg.sv
// ds_operand_unit_pkg: shared default widths for the decode-stage operand unit.
package ds_operand_unit_pkg;
   localparam int DATA_W_DEF  = 32;
   localparam int BUS_WD_DEF  = 64;
   localparam int NUM_FWD_DEF = 3;
   localparam int REG_AW_DEF  = 5;
   localparam int CNT_W_DEF   = 16;
endpackage

// File: rtl/ds_fwd_sel.sv
// ds_fwd_sel: single-operand forwarding match, youngest-wins mux and not-ready flag.
module ds_fwd_sel
   import ds_operand_unit_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_AW  = REG_AW_DEF,
   parameter int NUM_FWD = NUM_FWD_DEF
) (
   input  logic                      src_en,
   input  logic [REG_AW-1:0]         src,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD-1:0]        fwd_ready,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
   input  logic [DATA_W-1:0]         rf_rdata,
   output logic [DATA_W-1:0]         value,
   output logic                      not_ready
);
   // Scan oldest to youngest so the lowest-index hit is applied last and wins.
   always_comb begin
      value     = (src_en && src == '0) ? '0 : rf_rdata;
      not_ready = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--)
         if (src_en && src != '0 && fwd_valid[i] && fwd_dest[i*REG_AW +: REG_AW] == src) begin
            value     = fwd_data[i*DATA_W +: DATA_W];
            not_ready = !fwd_ready[i];
         end
   end
endmodule

// File: rtl/ds_operand_unit.sv
// ds_operand_unit: decode pipeline register with generic forwarding interlock and stall counter.
module ds_operand_unit
   import ds_operand_unit_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int BUS_WD  = BUS_WD_DEF,
   parameter int NUM_FWD = NUM_FWD_DEF,
   parameter int REG_AW  = REG_AW_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_allowin,
   input  logic [BUS_WD-1:0]         in_bus,
   input  logic [REG_AW-1:0]         in_src1,
   input  logic [REG_AW-1:0]         in_src2,
   input  logic                      in_src1_en,
   input  logic                      in_src2_en,
   output logic                      out_valid,
   input  logic                      out_allowin,
   output logic [BUS_WD-1:0]         out_bus,
   output logic [REG_AW-1:0]         rf_raddr1,
   output logic [REG_AW-1:0]         rf_raddr2,
   input  logic [DATA_W-1:0]         rf_rdata1,
   input  logic [DATA_W-1:0]         rf_rdata2,
   input  logic [NUM_FWD-1:0]        fwd_valid,
   input  logic [NUM_FWD-1:0]        fwd_ready,
   input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
   input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
   output logic [DATA_W-1:0]         src1_value,
   output logic [DATA_W-1:0]         src2_value,
   output logic                      br_stall,
   output logic [CNT_W-1:0]          stall_cnt
);
   logic              ds_valid;
   logic [REG_AW-1:0] src1_r, src2_r;
   logic              en1_r, en2_r;
   logic              nr1, nr2;
   logic              stall;

   ds_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel1 (
      .src_en(en1_r), .src(src1_r), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
      .fwd_dest(fwd_dest), .fwd_data(fwd_data), .rf_rdata(rf_rdata1),
      .value(src1_value), .not_ready(nr1)
   );

   ds_fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_sel2 (
      .src_en(en2_r), .src(src2_r), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
      .fwd_dest(fwd_dest), .fwd_data(fwd_data), .rf_rdata(rf_rdata2),
      .value(src2_value), .not_ready(nr2)
   );

   assign stall      = ds_valid && (nr1 || nr2);
   assign br_stall   = stall;
   assign out_valid  = ds_valid && !stall;
   assign in_allowin = !ds_valid || (!stall && out_allowin);
   assign rf_raddr1  = src1_r;
   assign rf_raddr2  = src2_r;

   // Flush kills both the held and the incoming instruction; the counter survives it.
   always_ff @(posedge clk) begin
      if (reset) begin
         ds_valid  <= 1'b0;
         out_bus   <= '0;
         src1_r    <= '0;
         src2_r    <= '0;
         en1_r     <= 1'b0;
         en2_r     <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (flush)
            ds_valid <= 1'b0;
         else if (in_allowin)
            ds_valid <= in_valid;
         if (in_valid && in_allowin) begin
            out_bus <= in_bus;
            src1_r  <= in_src1;
            src2_r  <= in_src2;
            en1_r   <= in_src1_en;
            en2_r   <= in_src2_en;
         end
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_ds_operand_unit.sv
// tb_ds_operand_unit: directed scenario tests for ds_operand_unit (default and 4-bit counter instances).
module tb_ds_operand_unit;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_allowin;
   logic [63:0] in_bus;
   logic [4:0]  in_src1, in_src2;
   logic        in_src1_en, in_src2_en;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [2:0]  fwd_valid, fwd_ready;
   logic [14:0] fwd_dest;
   logic [95:0] fwd_data;

   logic        in_allowin, out_valid, br_stall;
   logic [63:0] out_bus;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] src1_value, src2_value;
   logic [15:0] stall_cnt;

   logic        in_allowin_s, out_valid_s, br_stall_s;
   logic [63:0] out_bus_s;
   logic [4:0]  rf_raddr1_s, rf_raddr2_s;
   logic [31:0] src1_value_s, src2_value_s;
   logic [3:0]  stall_cnt_s;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   ds_operand_unit dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_allowin(in_allowin),
      .in_bus(in_bus), .in_src1(in_src1), .in_src2(in_src2), .in_src1_en(in_src1_en),
      .in_src2_en(in_src2_en), .out_valid(out_valid), .out_allowin(out_allowin),
      .out_bus(out_bus), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid),
      .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .src1_value(src1_value), .src2_value(src2_value), .br_stall(br_stall),
      .stall_cnt(stall_cnt)
   );

   ds_operand_unit #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_allowin(in_allowin_s),
      .in_bus(in_bus), .in_src1(in_src1), .in_src2(in_src2), .in_src1_en(in_src1_en),
      .in_src2_en(in_src2_en), .out_valid(out_valid_s), .out_allowin(out_allowin),
      .out_bus(out_bus_s), .rf_raddr1(rf_raddr1_s), .rf_raddr2(rf_raddr2_s),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid),
      .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .src1_value(src1_value_s), .src2_value(src2_value_s), .br_stall(br_stall_s),
      .stall_cnt(stall_cnt_s)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_allowin !== 1'b1) begin fails++; $display("FAIL reset_in_allowin: got %b want 1", in_allowin); end
      checks++; if (br_stall !== 1'b0) begin fails++; $display("FAIL reset_br_stall: got %b want 0", br_stall); end
      checks++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
      checks++; if (out_bus !== 64'd0 || rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd0) begin fails++; $display("FAIL reset_regs: bus %h a1 %0d a2 %0d want 0", out_bus, rf_raddr1, rf_raddr2); end
   endtask

   task automatic test_independent();
      in_valid = 1'b1; in_src1 = 5'd3; in_src2 = 5'd4; in_src1_en = 1'b1; in_src2_en = 1'b1;
      rf_rdata1 = 32'h11; rf_rdata2 = 32'h22; fwd_valid = 3'b000; out_allowin = 1'b1;
      in_bus = 64'd100;
      for (int i = 0; i < 4; i++) begin
         step();
         in_bus = 64'd101 + 64'(i);
         if (i == 3) in_valid = 1'b0;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || in_allowin !== 1'b1) begin fails++; $display("FAIL indep_handshake[%0d]: ov %b ia %b want 1 1", i, out_valid, in_allowin); end
         checks++; if (out_bus !== 64'd100 + 64'(i)) begin fails++; $display("FAIL indep_bus[%0d]: got %0d want %0d", i, out_bus, 100 + i); end
         checks++; if (src1_value !== 32'h11 || src2_value !== 32'h22) begin fails++; $display("FAIL indep_values[%0d]: got %h %h want 11 22", i, src1_value, src2_value); end
      end
      checks++; if (rf_raddr1 !== 5'd3 || rf_raddr2 !== 5'd4) begin fails++; $display("FAIL indep_raddr: got %0d %0d want 3 4", rf_raddr1, rf_raddr2); end
      step();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0) begin fails++; $display("FAIL indep_drain: ov %b cnt %0d want 0 0", out_valid, stall_cnt); end
   endtask

   task automatic test_priority();
      in_valid = 1'b1; in_src1 = 5'd5; in_src2 = 5'd0; in_src1_en = 1'b1; in_src2_en = 1'b1;
      in_bus = 64'h150;
      fwd_valid = 3'b111; fwd_ready = 3'b101;
      fwd_dest = {5'd5, 5'd0, 5'd5};
      fwd_data = {32'hC, 32'hB, 32'hA};
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (src1_value !== 32'hA) begin fails++; $display("FAIL prio_youngest: got %h want a", src1_value); end
      checks++; if (src2_value !== 32'h0) begin fails++; $display("FAIL prio_zero_src: got %h want 0", src2_value); end
      checks++; if (out_valid !== 1'b1 || br_stall !== 1'b0) begin fails++; $display("FAIL prio_no_stall: ov %b bs %b want 1 0", out_valid, br_stall); end
      fwd_ready = 3'b100;
      #1;
      checks++; if (out_valid !== 1'b0 || br_stall !== 1'b1 || in_allowin !== 1'b0) begin fails++; $display("FAIL prio_young_not_ready: ov %b bs %b ia %b want 0 1 0", out_valid, br_stall, in_allowin); end
      fwd_valid = 3'b110; fwd_ready = 3'b111;
      #1;
      checks++; if (src1_value !== 32'hC || out_valid !== 1'b1) begin fails++; $display("FAIL prio_oldest: val %h ov %b want c 1", src1_value, out_valid); end
      step();
      fwd_valid = 3'b000;
   endtask

   task automatic test_load_interlock();
      in_valid = 1'b1; in_src1 = 5'd7; in_src2 = 5'd7; in_src1_en = 1'b0; in_src2_en = 1'b1;
      in_bus = 64'h200; rf_rdata1 = 32'h11; rf_rdata2 = 32'h22;
      fwd_valid = 3'b001; fwd_ready = 3'b000;
      fwd_dest = {5'd0, 5'd0, 5'd7};
      fwd_data = {32'h0, 32'h0, 32'h77};
      step();
      in_valid = 1'b0; in_bus = 64'h300;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0 || br_stall !== 1'b1 || in_allowin !== 1'b0) begin fails++; $display("FAIL load_stall[%0d]: ov %b bs %b ia %b want 0 1 0", i, out_valid, br_stall, in_allowin); end
         step();
      end
      fwd_ready = 3'b001;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || br_stall !== 1'b0) begin fails++; $display("FAIL load_release: ov %b bs %b want 1 0", out_valid, br_stall); end
      checks++; if (src2_value !== 32'h77) begin fails++; $display("FAIL load_fwd_value: got %h want 77", src2_value); end
      checks++; if (src1_value !== 32'h11) begin fails++; $display("FAIL load_src_disabled: got %h want 11", src1_value); end
      checks++; if (stall_cnt !== 16'd2) begin fails++; $display("FAIL load_cnt: got %0d want 2", stall_cnt); end
      step();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd2) begin fails++; $display("FAIL load_after: ov %b cnt %0d want 0 2", out_valid, stall_cnt); end
      fwd_valid = 3'b000;
   endtask

   task automatic test_backpressure();
      out_allowin = 1'b0; in_valid = 1'b1; in_src1 = 5'd3; in_src2 = 5'd4;
      in_src1_en = 1'b1; in_src2_en = 1'b1; in_bus = 64'h400;
      step();
      in_bus = 64'h500; in_src1 = 5'd9;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (in_allowin !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_handshake[%0d]: ia %b ov %b want 0 1", i, in_allowin, out_valid); end
         checks++; if (out_bus !== 64'h400 || rf_raddr1 !== 5'd3) begin fails++; $display("FAIL bp_hold[%0d]: bus %h a1 %0d want 400 3", i, out_bus, rf_raddr1); end
         checks++; if (stall_cnt !== 16'd2) begin fails++; $display("FAIL bp_cnt[%0d]: got %0d want 2", i, stall_cnt); end
         step();
      end
      out_allowin = 1'b1;
      @(negedge clk);
      checks++; if (in_allowin !== 1'b1) begin fails++; $display("FAIL bp_release: ia %b want 1", in_allowin); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_bus !== 64'h500 || rf_raddr1 !== 5'd9 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_next: bus %h a1 %0d ov %b want 500 9 1", out_bus, rf_raddr1, out_valid); end
      step();
   endtask

   task automatic test_flush();
      in_valid = 1'b1; in_src2 = 5'd7; in_src2_en = 1'b1; in_bus = 64'h600;
      fwd_valid = 3'b001; fwd_ready = 3'b000; fwd_dest = {5'd0, 5'd0, 5'd7};
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || br_stall !== 1'b1) begin fails++; $display("FAIL flush_setup: ov %b bs %b want 0 1", out_valid, br_stall); end
      step();
      flush = 1'b1; in_valid = 1'b1; in_bus = 64'h700;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || br_stall !== 1'b0 || in_allowin !== 1'b1) begin fails++; $display("FAIL flush_kill: ov %b bs %b ia %b want 0 0 1", out_valid, br_stall, in_allowin); end
      checks++; if (stall_cnt !== 16'd4) begin fails++; $display("FAIL flush_cnt: got %0d want 4", stall_cnt); end
      checks++; if (out_bus !== 64'h600) begin fails++; $display("FAIL flush_no_capture: got %h want 600", out_bus); end
      fwd_valid = 3'b000;
      flush = 1'b1; in_valid = 1'b1; in_bus = 64'h710;
      step();
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop_incoming: ov %b want 0", out_valid); end
   endtask

   task automatic test_saturation();
      reset = 1'b1; in_valid = 1'b0;
      step();
      @(negedge clk);
      checks++; if (stall_cnt !== 16'd0 || stall_cnt_s !== 4'd0) begin fails++; $display("FAIL sat_reset: cnt %0d cnt_s %0d want 0 0", stall_cnt, stall_cnt_s); end
      reset = 1'b0; in_valid = 1'b1; in_src2 = 5'd7; in_src2_en = 1'b1; in_bus = 64'h800;
      fwd_valid = 3'b001; fwd_ready = 3'b000; fwd_dest = {5'd0, 5'd0, 5'd7};
      step();
      in_valid = 1'b0;
      repeat (20) step();
      @(negedge clk);
      checks++; if (stall_cnt_s !== 4'd15) begin fails++; $display("FAIL sat_cnt4: got %0d want 15", stall_cnt_s); end
      checks++; if (stall_cnt !== 16'd20) begin fails++; $display("FAIL sat_cnt16: got %0d want 20", stall_cnt); end
      checks++; if (br_stall_s !== 1'b1) begin fails++; $display("FAIL sat_still_stalled: got %b want 1", br_stall_s); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || br_stall !== 1'b0 || stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_mid_stall: ov %b bs %b cnt %0d want 0 0 0", out_valid, br_stall, stall_cnt); end
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b1; in_bus = '0;
      in_src1 = '0; in_src2 = '0; in_src1_en = 1'b0; in_src2_en = 1'b0;
      rf_rdata1 = '0; rf_rdata2 = '0; fwd_valid = '0; fwd_ready = '0; fwd_dest = '0; fwd_data = '0;
      step();
      step();
      test_reset();
      reset = 1'b0;
      step();
      test_independent();
      test_priority();
      test_load_interlock();
      test_backpressure();
      test_flush();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
